canny_vga_display: RTL and testbench
====================================

// Module: canny_vga_display
// PURPOSE
//   Downstream display stage of the Canny pipeline. Scans a 640x480@60 VGA raster
//   and fetches pixels from the result memories (X, XG, Gxy, ThetaT, GxyT, bGxyT)
//   over a shared read address. Draws the selected image as a window inside the raster.
//   Memories are read-only from this block; their write enables are owned by the sequencer.
// PARAMETERS
//   IMG_W     200  image width in pixels
//   IMG_H     200  image height in pixels; IMG_W*IMG_H <= 65536
//   WIN_X0    220  raster column of the window's left edge
//   WIN_Y0    140  raster row of the window's top edge
//   H_ACT/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing (H_TOTAL = 800)
//   V_ACT/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing (V_TOTAL = 525)
// PORTS
//   pclk         in   1   pixel clock (25 MHz); also clocks all memories
//   rst_b        in   1   asynchronous, active-low reset
//   src_sel      in   3   0 X, 1 XG, 2 Gxy, 3 ThetaT, 4 GxyT, 5 bGxyT, 6/7 black
//   rd_addr      out  16  shared read address to all six memories
//   X_douta      in   8   memX read data
//   XG_douta     in   8   memXG read data
//   Gxy_douta    in   8   memGxy read data
//   ThetaT_douta in   24  memThetaT read data, {R,G,B}
//   GxyT_douta   in   8   memGxyT read data
//   bGxyT_douta  in   8   membGxyT read data
//   vga_r/g/b    out  4   colour outputs
//   vga_hs       out  1   hsync, active low
//   vga_vs       out  1   vsync, active low
//   frame_start  out  1   one-cycle pulse when the counters are at (0,0)
// BEHAVIOUR
//   Reset values: h_cnt=0, v_cnt=0, rd_addr=0, vga_r/g/b=0, vga_hs=1, vga_vs=1,
//     frame_start=0, sel_q=0. Reset mid-frame aborts the frame; the raster restarts at (0,0).
//   Counters: h_cnt runs 0..799 and wraps to 0. v_cnt increments on each h wrap,
//     runs 0..524 and wraps to 0.
//   Source select: sel_q <= src_sel only in the cycle where h_cnt==0 and v_cnt==0.
//     Changes to src_sel during a frame have no effect until the next frame.
//   Window: in_win = h_cnt in [WIN_X0, WIN_X0+IMG_W) and v_cnt in [WIN_Y0, WIN_Y0+IMG_H).
//     col = h_cnt-WIN_X0; row = v_cnt-WIN_Y0.
//   Address generation uses no multiplier; a row_base register is updated per line.
//     Normal (sel 0,1,2,4): addr = row*IMG_W + col.
//     Flipped (sel 3,5): addr = (IMG_H-1-row)*IMG_W + col, because these memories are
//       stored bottom-up.
//     row_base loads at window row 0. It steps by +IMG_W (normal) or -IMG_W (flipped)
//       after the last window column of each row.
//     Outside the window rd_addr holds its last value.
//   Pipeline, 3-cycle latency. For the counter state (h,v) in cycle n:
//     cycle n+1: rd_addr registered.
//     cycle n+2: memory data valid (synchronous 1-cycle read).
//     cycle n+3: RGB registered.
//     in_win, active, hs and vs go through a 3-stage delay line so that the sync pins,
//       blanking and colour stay aligned.
//   Colour mapping, applied in cycle n+2 and registered into n+3:
//     8-bit sources: R=G=B=data[7:4].
//     ThetaT: R=d[23:20], G=d[15:12], B=d[7:4].
//     bGxyT: R=G=B = (d!=0) ? 4'hF : 4'h0.
//     sel 6/7, out-of-window active pixels, and blanking: RGB=0.
//   Sync (before delay): hs=0 when h_cnt in [656,752); vs=0 when v_cnt in [490,492).
//   frame_start is registered from (h_cnt==0 && v_cnt==0) and is not delayed.
// TESTING
//   1. Release reset, run 2 frames -> hs low 96 of every 800 cycles; vs low 1600 cycles
//      per 420000-cycle frame.
//   2. sel=1, XG model returns addr[7:0]. First window pixel at (220,140) -> rd_addr=0;
//      RGB=0 on pins 3 cycles later. (221,140) -> rd_addr=1. (220,141) -> rd_addr=200.
//   3. sel=3, ThetaT=24'hFF00FF at all addresses -> window row 0 reads rd_addr=39800;
//      pins show R=F, G=0, B=F. Pixels outside the window read 0.
//   4. sel=5, bGxyT=8'h01 -> 4'hF grey. Change sel to 0 at v_cnt=300 -> the output stays
//      bGxyT until the next frame_start, then X.
//   5. Assert rst_b low at h=400, v=250 for 3 cycles -> outputs at reset values;
//      counters restart at 0; frame_start pulses one cycle after release.
//   6. sel=7 for a whole frame -> RGB=0 for every cycle; sync timing unchanged.

Source files
------------

// File: rtl/canny_vga_display.sv
// canny_vga_display: scans a VGA raster and shows one Canny result memory as a window.
// Read address, memory data and colour form a 3-cycle pipeline; sync/blank follow the same delay.
module canny_vga_display #(
  parameter int unsigned IMG_W  = 200,
  parameter int unsigned IMG_H  = 200,
  parameter int unsigned WIN_X0 = 220,
  parameter int unsigned WIN_Y0 = 140,
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic        pclk,
  input  logic        rst_b,
  input  logic [2:0]  src_sel,
  output logic [15:0] rd_addr,
  input  logic [7:0]  X_douta,
  input  logic [7:0]  XG_douta,
  input  logic [7:0]  Gxy_douta,
  input  logic [23:0] ThetaT_douta,
  input  logic [7:0]  GxyT_douta,
  input  logic [7:0]  bGxyT_douta,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL   = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned AW        = 16;
  localparam int unsigned HS_BEG    = H_ACT + H_FP;
  localparam int unsigned HS_END    = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG    = V_ACT + V_FP;
  localparam int unsigned VS_END    = VS_BEG + V_SYNC;
  localparam int unsigned FLIP_BASE = (IMG_H - 1) * IMG_W;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [2:0]    sel_q;
  logic [AW-1:0] row_base;
  logic [1:0]    in_win_d;
  logic [1:0]    active_d;
  logic [1:0]    hs_d;
  logic [1:0]    vs_d;

  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          at_origin_c;
  logic          in_win_c;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;
  logic          flip_c;
  logic          last_col_c;
  logic [2:0]    sel_eff_c;
  logic [AW-1:0] col_c;
  logic [AW-1:0] base_c;
  logic [11:0]   rgb_c;
  logic          unused_c;

  // Raster decode, window test and row base selection for the current counter state.
  always_comb begin
    h_wrap_c    = (h_cnt == HW'(H_TOTAL - 1));
    v_wrap_c    = (v_cnt == VW'(V_TOTAL - 1));
    at_origin_c = (h_cnt == '0) && (v_cnt == '0);
    in_win_c    = (h_cnt >= HW'(WIN_X0)) && (h_cnt < HW'(WIN_X0 + IMG_W)) &&
                  (v_cnt >= VW'(WIN_Y0)) && (v_cnt < VW'(WIN_Y0 + IMG_H));
    active_c    = (h_cnt < HW'(H_ACT)) && (v_cnt < VW'(V_ACT));
    hs_c        = !((h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END)));
    vs_c        = !((v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END)));
    // At the origin the new frame's selection is the one being latched.
    sel_eff_c   = at_origin_c ? src_sel : sel_q;
    flip_c      = (sel_eff_c == 3'd3) || (sel_eff_c == 3'd5);
    last_col_c  = in_win_c && (h_cnt == HW'(WIN_X0 + IMG_W - 1));
    col_c       = AW'(h_cnt) - AW'(WIN_X0);
    // Window row 0 takes the start address directly; later rows use row_base.
    if (v_cnt == VW'(WIN_Y0)) begin
      base_c = flip_c ? AW'(FLIP_BASE) : '0;
    end else begin
      base_c = row_base;
    end
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap_c) begin
      h_cnt <= '0;
      v_cnt <= v_wrap_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Source selection is frozen for a whole frame; frame_start marks the origin.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      sel_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      if (at_origin_c) sel_q <= src_sel;
      frame_start <= at_origin_c;
    end
  end

  // Row base steps one image line after the last window column (down for bottom-up memories).
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      row_base <= '0;
    end else if (last_col_c) begin
      row_base <= flip_c ? base_c - AW'(IMG_W) : base_c + AW'(IMG_W);
    end
  end

  // Shared read address; holds outside the window.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      rd_addr <= '0;
    end else if (in_win_c) begin
      rd_addr <= base_c + col_c;
    end
  end

  // Two delay stages for window/blank/sync; the output registers form the third.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      in_win_d <= '0;
      active_d <= '0;
      hs_d     <= '1;
      vs_d     <= '1;
    end else begin
      in_win_d <= {in_win_d[0], in_win_c};
      active_d <= {active_d[0], active_c};
      hs_d     <= {hs_d[0], hs_c};
      vs_d     <= {vs_d[0], vs_c};
    end
  end

  // Colour mapping of the memory data for the selected source.
  always_comb begin
    rgb_c = '0;
    if (in_win_d[1] && active_d[1]) begin
      case (sel_q)
        3'd0:    rgb_c = {3{X_douta[7:4]}};
        3'd1:    rgb_c = {3{XG_douta[7:4]}};
        3'd2:    rgb_c = {3{Gxy_douta[7:4]}};
        3'd3:    rgb_c = {ThetaT_douta[23:20], ThetaT_douta[15:12], ThetaT_douta[7:4]};
        3'd4:    rgb_c = {3{GxyT_douta[7:4]}};
        3'd5:    rgb_c = (bGxyT_douta != 8'd0) ? 12'hFFF : 12'h000;
        default: rgb_c = '0;
      endcase
    end
  end

  // Output registers: colour and sync pins.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_c;
      vga_hs <= hs_d[1];
      vga_vs <= vs_d[1];
    end
  end

  // Low nibbles of the greyscale sources are intentionally dropped.
  assign unused_c = ^{X_douta[3:0], XG_douta[3:0], Gxy_douta[3:0], GxyT_douta[3:0],
                      ThetaT_douta[19:16], ThetaT_douta[11:8], ThetaT_douta[3:0]};

endmodule

// File: tb/tb_canny_vga_display.sv
// tb_canny_vga_display: reduced-raster bench comparing every cycle against a position-based model.
module tb_canny_vga_display;

  localparam int unsigned IMG_W  = 16;
  localparam int unsigned IMG_H  = 12;
  localparam int unsigned WIN_X0 = 20;
  localparam int unsigned WIN_Y0 = 10;
  localparam int unsigned H_ACT  = 64;
  localparam int unsigned H_FP   = 4;
  localparam int unsigned H_SYNC = 8;
  localparam int unsigned H_BP   = 4;
  localparam int unsigned V_ACT  = 48;
  localparam int unsigned V_FP   = 2;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 3;
  localparam int unsigned H_T    = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_T    = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME  = H_T * V_T;
  localparam int unsigned P0     = WIN_Y0 * H_T + WIN_X0;

  logic        pclk;
  logic        rst_b;
  logic [2:0]  src_sel;
  logic [15:0] rd_addr;
  logic [7:0]  x_q, xg_q, gxy_q, gxyt_q, bg_q;
  logic [23:0] th_q;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  // memory content keys
  logic [7:0]  x_key, xg_key, gxy_key, gxyt_key, th_mask, bg_mask, bg_const;
  logic [23:0] th_key;

  // model state
  int unsigned k;
  logic [2:0]  mdl_sel;
  logic [15:0] mdl_addr;
  int unsigned n_checks, n_fail;
  int unsigned hs_low, vs_low, rgb_nz;

  canny_vga_display #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .pclk(pclk), .rst_b(rst_b), .src_sel(src_sel), .rd_addr(rd_addr),
    .X_douta(x_q), .XG_douta(xg_q), .Gxy_douta(gxy_q), .ThetaT_douta(th_q),
    .GxyT_douta(gxyt_q), .bGxyT_douta(bg_q),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [7:0] mem8(input logic [15:0] a, input logic [7:0] key);
    return 8'(a) ^ key;
  endfunction
  function automatic logic [23:0] mem_th(input logic [15:0] a);
    return th_key ^ {8'(a) & th_mask, 8'h00, 8'(a) & th_mask};
  endfunction
  function automatic logic [7:0] mem_bg(input logic [15:0] a);
    return (8'(a) & bg_mask) | bg_const;
  endfunction

  // synchronous-read memory models
  always @(posedge pclk) begin
    x_q    <= mem8(rd_addr, x_key);
    xg_q   <= mem8(rd_addr, xg_key);
    gxy_q  <= mem8(rd_addr, gxy_key);
    gxyt_q <= mem8(rd_addr, gxyt_key);
    th_q   <= mem_th(rd_addr);
    bg_q   <= mem_bg(rd_addr);
  end

  function automatic int unsigned hpos(input int unsigned kk);
    return (kk % FRAME) % H_T;
  endfunction
  function automatic int unsigned vpos(input int unsigned kk);
    return (kk % FRAME) / H_T;
  endfunction
  function automatic bit in_win(input int unsigned h, input int unsigned v);
    return (h >= WIN_X0) && (h < WIN_X0 + IMG_W) && (v >= WIN_Y0) && (v < WIN_Y0 + IMG_H);
  endfunction
  function automatic bit is_flip(input logic [2:0] s);
    return (s == 3'd3) || (s == 3'd5);
  endfunction
  function automatic logic [15:0] addr_of(input int unsigned h, input int unsigned v, input bit flip);
    int unsigned row, col;
    row = v - WIN_Y0;
    col = h - WIN_X0;
    return flip ? 16'((IMG_H - 1 - row) * IMG_W + col) : 16'(row * IMG_W + col);
  endfunction
  function automatic logic [11:0] grey(input logic [7:0] d);
    return 12'((int'(d) / 16) * 273);
  endfunction
  function automatic logic [11:0] colour(input int unsigned h, input int unsigned v, input logic [2:0] s);
    logic [15:0] a;
    logic [23:0] t;
    if (!in_win(h, v)) return 12'h000;
    a = addr_of(h, v, is_flip(s));
    t = mem_th(a);
    case (s)
      3'd0: return grey(mem8(a, x_key));
      3'd1: return grey(mem8(a, xg_key));
      3'd2: return grey(mem8(a, gxy_key));
      3'd3: return 12'(((t >> 20) & 24'hF) * 256 + ((t >> 12) & 24'hF) * 16 + ((t >> 4) & 24'hF));
      3'd4: return grey(mem8(a, gxyt_key));
      3'd5: return (mem_bg(a) != 8'd0) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  // one clock: advance model, compare all outputs
  task automatic step();
    int unsigned ph, pv, qh, qv;
    logic        exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    @(posedge pclk);
    #1;
    k++;
    ph = hpos(k - 1);
    pv = vpos(k - 1);
    if (ph == 0 && pv == 0) mdl_sel = src_sel;
    if (in_win(ph, pv)) mdl_addr = addr_of(ph, pv, is_flip(mdl_sel));
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    exp_rgb = 12'h000;
    if (k >= 3) begin
      qh = hpos(k - 3);
      qv = vpos(k - 3);
      exp_hs  = !(qh >= H_ACT + H_FP && qh < H_ACT + H_FP + H_SYNC);
      exp_vs  = !(qv >= V_ACT + V_FP && qv < V_ACT + V_FP + V_SYNC);
      exp_rgb = colour(qh, qv, mdl_sel);
    end
    check("frame_start", frame_start, (ph == 0 && pv == 0));
    check("rd_addr", rd_addr, mdl_addr);
    check("hs", vga_hs, exp_hs);
    check("vs", vga_vs, exp_vs);
    check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
    if (!vga_hs) hs_low++;
    if (!vga_vs) vs_low++;
    if ({vga_r, vga_g, vga_b} != 12'h000) rgb_nz++;
  endtask

  task automatic run_to(input int unsigned p);
    for (int i = 0; i <= int'(FRAME) && (k % FRAME) != p; i++) step();
    if ((k % FRAME) != p) check("run_to_bound", k % FRAME, p);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, rd_addr, 16'h0000);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    check({tag, "_hs"}, vga_hs, 1'b1);
    check({tag, "_vs"}, vga_vs, 1'b1);
    check({tag, "_fs"}, frame_start, 1'b0);
  endtask

  // assert reset for three clocks, then release with the model back at the origin
  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    check_reset_vals("rst_in");
    repeat (3) @(posedge pclk);
    #1;
    check_reset_vals("rst_hold");
    rst_b    = 1'b1;
    k        = 0;
    mdl_sel  = 3'd0;
    mdl_addr = 16'h0000;
  endtask

  task automatic count_frame(input string tag);
    hs_low = 0;
    vs_low = 0;
    rgb_nz = 0;
    repeat (FRAME) step();
    check({tag, "_hs_low"}, hs_low, V_T * H_SYNC);
    check({tag, "_vs_low"}, vs_low, V_SYNC * H_T);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", k);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; k = 0;
    hs_low = 0; vs_low = 0; rgb_nz = 0;
    mdl_sel = 3'd0; mdl_addr = 16'h0000;
    rst_b = 1'b1;
    src_sel = 3'd1;
    x_key = 8'h00; xg_key = 8'h00; gxy_key = 8'h3C; gxyt_key = 8'hC3;
    th_key = 24'h123456; th_mask = 8'hFF; bg_mask = 8'h0F; bg_const = 8'h00;
    #2;
    do_reset();

    // XG with data = addr[7:0]; sync counts over two frames
    count_frame("f0");
    count_frame("f1");
    run_to(P0 + 1);
    check("xg_first_addr", rd_addr, 16'd0);
    run_to(P0 + 2);
    check("xg_second_addr", rd_addr, 16'd1);
    run_to(P0 + 3);
    check("xg_first_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    run_to(P0 + H_T + 1);
    check("xg_row1_addr", rd_addr, 16'(IMG_W));

    // ThetaT constant magenta, bottom-up addressing
    run_to(5);
    src_sel = 3'd3; th_key = 24'hFF00FF; th_mask = 8'h00;
    run_to(0);
    run_to(P0 + 1);
    check("th_row0_addr", rd_addr, 16'((IMG_H - 1) * IMG_W));
    run_to(P0 + 3);
    check("th_rgb", {vga_r, vga_g, vga_b}, 12'hF0F);
    run_to(P0 + IMG_W + 3);
    check("th_outside_rgb", {vga_r, vga_g, vga_b}, 12'h000);

    // bGxyT constant 1; mid-frame change to X must wait for the next frame
    run_to(5);
    src_sel = 3'd5; bg_mask = 8'h00; bg_const = 8'h01; x_key = 8'hA5;
    run_to(0);
    run_to((WIN_Y0 + 5) * H_T);
    src_sel = 3'd0;
    run_to((WIN_Y0 + 6) * H_T + WIN_X0 + 3);
    check("bg_hold_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
    run_to(0);
    run_to(P0 + 3);
    check("x_after_frame_rgb", {vga_r, vga_g, vga_b}, 12'hAAA);

    // reset mid-frame, then a black frame
    run_to(25 * H_T + 40);
    do_reset();
    src_sel = 3'd7;
    count_frame("black");
    check("black_rgb_nonzero", rgb_nz, 0);

    // randomized selections and memory contents
    for (int f = 0; f < 5; f++) begin
      run_to(5);
      x_key = 8'($urandom); xg_key = 8'($urandom); gxy_key = 8'($urandom);
      gxyt_key = 8'($urandom); th_key = 24'($urandom); th_mask = 8'($urandom);
      bg_mask = 8'($urandom); bg_const = 8'($urandom_range(0, 1));
      src_sel = 3'($urandom_range(0, 7));
      run_to(5 + $urandom_range(10, FRAME - 20));
      src_sel = 3'($urandom_range(0, 7));
      run_to(0);
    end
    run_to(FRAME / 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
